stm_focus_writer: RTL and testbench
===================================

// Module: stm_focus_writer
// PURPOSE
//  Write side of the focus STM memory. Takes a stream of 16-bit host words, packs each group of 4 into one
//  64-bit focus entry (x, y, z, intensity) and writes the entry to the focus BRAM at a running index.
//  Sits between the host bus decoder and the focus STM memory that the focus STM engine reads through STM_BUS.
// PARAMETERS
//  DEPTH      8192  focus entries in memory; MEM_ADDR wraps to 0 after DEPTH-1
//  WORD_W     16    host word width; fixed, 4 words per entry
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   synchronous reset, active-high
//  START      in   1   1-cycle pulse; latches START_IDX and COUNT, begins a burst
//  START_IDX  in   13  first entry index of the burst
//  COUNT      in   14  number of entries in the burst (0..DEPTH)
//  DIN        in   16  host word
//  DIN_VALID  in   1   DIN is valid
//  DIN_READY  out  1   block accepts DIN this cycle (transfer = VALID & READY)
//  MEM_WE     out  1   1-cycle BRAM write strobe
//  MEM_ADDR   out  13  BRAM entry index
//  MEM_DIN    out  64  packed entry
//  BUSY       out  1   burst in progress
//  DONE       out  1   1-cycle pulse when the burst completes
//  ERR        out  1   sticky range error, cleared by START (only with the macro)
// BEHAVIOUR
//  Reset: state IDLE; DIN_READY=0, MEM_WE=0, MEM_ADDR=0, MEM_DIN=0, BUSY=0, DONE=0, ERR=0; partial entry dropped.
//  Entry layout {w3,w2,w1,w0}: [17:0] x s18, [35:18] y s18, [53:36] z s18, [61:54] intensity, [63:62] reserved.
//  FSM IDLE -> COLLECT on START (COUNT!=0). START with COUNT==0: DONE pulses next cycle, stays IDLE.
//  COLLECT: DIN_READY=1. Each transfer shifts DIN into word slot wcnt (0..3) and increments wcnt.
//   4th transfer -> WRITE.
//  WRITE: DIN_READY=0; MEM_WE=1 for exactly one cycle with MEM_ADDR=idx and MEM_DIN=entry.
//   Latency from the 4th transfer to MEM_WE is 1 cycle. Then idx=idx+1 (DEPTH-1 wraps to 0) and remain--.
//   If remain hits 0: -> IDLE, DONE=1 for one cycle. Otherwise -> COLLECT, wcnt=0.
//  Throughput: 1 entry per 5 cycles at full DIN_VALID.
//  START while BUSY: ignored, no effect on idx, remain or ERR.
//  DIN_VALID while not READY: word is not consumed; the source holds it.
//  RST mid-burst: abort immediately; no MEM_WE is issued for the partial entry.
//  BUSY=1 in COLLECT and WRITE; BUSY=0 in the DONE cycle.
// CONFIGURATION
//  STM_FOCUS_WRITER_RANGE_CHECK_EN defined:
//   In WRITE, an entry is bad if z[17]=1 (negative z) or reserved bits !=0.
//   A bad entry is not written (MEM_WE=0), but idx and remain still advance. ERR is set and stays sticky.
//  Not defined: every entry is written unchanged; ERR is tied to 0.
// STRUCTURE
//  Package stm_focus_pkg: FocusXLsb/YLsb/ZLsb/IntensityLsb, CoordWidth=18, WordsPerFocus=4, writer_state_t
//   (IDLE, COLLECT, WRITE). The focus STM engine imports the same layout constants.
//  Sub-module stm_focus_check: combinational range check, instantiated only under the macro.
// TESTING
//  1. START_IDX=5, COUNT=1, words 0x0010,0x0000,0x0000,0x0000 -> one MEM_WE, ADDR=5, DIN=64'h10, then DONE.
//  2. START_IDX=8191, COUNT=2, 8 words back-to-back -> writes at ADDR 8191 then 0; 10 cycles start-to-DONE.
//  3. DIN_VALID toggled 1/0 every cycle -> MEM_DIN identical to test 2; READY low only in WRITE cycles.
//  4. RST asserted after 2 of 4 words, then a new START with COUNT=1 -> no write from the aborted entry;
//     the new entry's words land in slots 0..3.
//  5. START with COUNT=0 -> DONE 1 cycle later, no MEM_WE. START pulsed mid-burst -> ignored.
//  6. With macro: entry with z=-1 (w2[5:4]=2'b11, bit53=1) -> no MEM_WE, ERR=1, next entry at idx+1 written;
//     without macro -> written, ERR=0.

Source files
------------

// File: rtl/stm_focus_pkg.sv
// stm_focus_pkg: focus entry layout shared by the focus STM writer and the
// focus STM engine that reads entries back, plus the writer state type.
package stm_focus_pkg;

  // Memory geometry
  localparam int unsigned Depth          = 8192;
  localparam int unsigned AddrWidth      = 13;
  localparam int unsigned CountWidth     = 14;

  // Host word and entry geometry
  localparam int unsigned WordWidth      = 16;
  localparam int unsigned WordsPerFocus  = 4;
  localparam int unsigned EntryWidth     = 64;

  // Field layout of one packed focus entry {w3,w2,w1,w0}
  localparam int unsigned CoordWidth     = 18;
  localparam int unsigned IntensityWidth = 8;
  localparam int unsigned ReservedWidth  = 2;
  localparam int unsigned FocusXLsb         = 0;
  localparam int unsigned FocusYLsb         = 18;
  localparam int unsigned FocusZLsb         = 36;
  localparam int unsigned FocusIntensityLsb = 54;
  localparam int unsigned FocusReservedLsb  = 62;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } writer_state_t;

  // Assemble one entry from four host words, w0 in the least significant slot.
  function automatic logic [EntryWidth-1:0] pack_focus(
    input logic [WordWidth-1:0] w3,
    input logic [WordWidth-1:0] w2,
    input logic [WordWidth-1:0] w1,
    input logic [WordWidth-1:0] w0
  );
    return {w3, w2, w1, w0};
  endfunction

endpackage

// File: rtl/stm_focus_check.sv
// stm_focus_check: combinational range check of one packed focus entry.
// Flags negative z and non-zero reserved bits. The module only exists when
// STM_FOCUS_WRITER_RANGE_CHECK_EN is defined, so the default build carries
// no unused module.
`ifdef STM_FOCUS_WRITER_RANGE_CHECK_EN
module stm_focus_check (
  input  logic       z_sign_i,
  input  logic [1:0] reserved_i,
  output logic       bad_o
);

  // An entry is rejected when z is negative or any reserved bit is set.
  always_comb begin
    bad_o = z_sign_i | (reserved_i != 2'b00);
  end

endmodule
`endif

// File: rtl/stm_focus_writer.sv
// stm_focus_writer: packs groups of four 16-bit host words into 64-bit focus
// entries and writes them to the focus BRAM at a running, wrapping index.
// Optional feature macro: STM_FOCUS_WRITER_RANGE_CHECK_EN (drops entries with
// negative z or non-zero reserved bits and raises a sticky ERR).
module stm_focus_writer
  import stm_focus_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [AddrWidth-1:0]  start_idx_i,
  input  logic [CountWidth-1:0] count_i,
  input  logic [WordWidth-1:0]  din_i,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  output logic                  mem_we_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [EntryWidth-1:0] mem_din_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned HeldWidth = WordWidth * (WordsPerFocus - 1);

  writer_state_t          state_q;
  logic [1:0]             wcnt_q;
  logic [HeldWidth-1:0]   words_q;   // w2..w0 of the entry being collected
  logic [AddrWidth-1:0]   idx_q;
  logic [CountWidth-1:0]  remain_q;
  logic                   ready_q;
  logic                   we_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [EntryWidth-1:0]  mem_din_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   xfer;
  logic [EntryWidth-1:0]  entry_d;
  logic [AddrWidth-1:0]   idx_d;
  logic                   bad_entry;

  // Transfer qualifier, the entry completed by the current word, next index.
  always_comb begin
    xfer    = din_valid_i & ready_q;
    entry_d = pack_focus(din_i, words_q[3*WordWidth-1:2*WordWidth],
                         words_q[2*WordWidth-1:WordWidth], words_q[WordWidth-1:0]);
    if (idx_q == AddrWidth'(Depth - 1)) begin
      idx_d = {AddrWidth{1'b0}};
    end else begin
      idx_d = idx_q + 13'd1;
    end
  end

`ifdef STM_FOCUS_WRITER_RANGE_CHECK_EN
  logic err_q;

  stm_focus_check u_check (
    .z_sign_i   (entry_d[FocusZLsb + CoordWidth - 1]),
    .reserved_i (entry_d[FocusReservedLsb +: ReservedWidth]),
    .bad_o      (bad_entry)
  );

  assign err_o = err_q;
`else
  assign bad_entry = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Burst FSM: accepts START, collects four words, issues one write per entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wcnt_q    <= 2'd0;
      words_q   <= {HeldWidth{1'b0}};
      idx_q     <= {AddrWidth{1'b0}};
      remain_q  <= {CountWidth{1'b0}};
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {AddrWidth{1'b0}};
      mem_din_q <= {EntryWidth{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef STM_FOCUS_WRITER_RANGE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
`ifdef STM_FOCUS_WRITER_RANGE_CHECK_EN
            err_q <= 1'b0;
`endif
            if (count_i != 14'd0) begin
              state_q  <= COLLECT;
              idx_q    <= start_idx_i;
              remain_q <= count_i;
              wcnt_q   <= 2'd0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              // Empty burst completes immediately without touching memory.
              done_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (xfer) begin
            wcnt_q <= wcnt_q + 2'd1;
            if (wcnt_q == 2'd3) begin
              state_q   <= WRITE;
              ready_q   <= 1'b0;
              addr_q    <= idx_q;
              mem_din_q <= entry_d;
              we_q      <= ~bad_entry;
`ifdef STM_FOCUS_WRITER_RANGE_CHECK_EN
              if (bad_entry) begin
                err_q <= 1'b1;
              end
`endif
            end else begin
              // Shift from the top so w0 ends up in the lowest slot.
              words_q <= {din_i, words_q[HeldWidth-1:WordWidth]};
            end
          end
        end
        WRITE: begin
          idx_q    <= idx_d;
          remain_q <= remain_q - 14'd1;
          if (remain_q == 14'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= COLLECT;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready_o = ready_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_din_o   = mem_din_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_stm_focus_writer.sv
// tb_stm_focus_writer: directed bench with an entry-level expectation model.
module tb_stm_focus_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] start_idx;
  logic [13:0] count;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_din;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  stm_focus_writer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .start_idx_i (start_idx),
    .count_i     (count),
    .din_i       (din),
    .din_valid_i (din_valid),
    .din_ready_o (din_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_din_o   (mem_din),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

`ifdef STM_FOCUS_WRITER_RANGE_CHECK_EN
  localparam bit RangeChk = 1'b1;
`else
  localparam bit RangeChk = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  bit chk_ready = 1'b0;

  logic [12:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic [12:0] log_addr[$];
  logic [63:0] log_data[$];

  logic [15:0] w1[$];
  logic [15:0] w2[$];
  logic [15:0] w4a[$];
  logic [15:0] w4b[$];
  logic [15:0] w5a[$];
  logic [15:0] w5b[$];
  logic [15:0] w5all[$];
  logic [15:0] w6[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // A bad entry is one the range check must drop.
  function automatic bit model_bad(input logic [63:0] e);
    return RangeChk && (e[53] || (e[63:62] != 2'b00));
  endfunction

  // Expected writes of a whole burst: entry k from words 4k..4k+3, at (idx+k) mod 8192.
  task automatic expect_burst(input int idx, input logic [15:0] w[$], input int cnt);
    logic [63:0] e;
    for (int k = 0; k < cnt; k++) begin
      e = {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
      if (!model_bad(e)) begin
        exp_addr_q.push_back(13'((idx + k) % 8192));
        exp_data_q.push_back(e);
      end
    end
  endtask

  // Per-cycle compare of the write port against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_we) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_din);
        check("busy_in_write", {63'd0, busy}, 64'd1);
        if (exp_addr_q.size() == 0) begin
          fail("unexpected_write");
        end else begin
          check("write_addr", {51'd0, mem_addr}, {51'd0, exp_addr_q.pop_front()});
          check("write_data", mem_din, exp_data_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_in_done", {63'd0, busy}, 64'd0);
      end
      if (chk_ready) begin
        check("ready_vs_write", {63'd0, din_ready}, {63'd0, busy & ~mem_we});
      end
    end
  end

  task automatic do_start(input int idx, input int cnt);
    start     = 1'b1;
    start_idx = 13'(idx);
    count     = 14'(cnt);
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_words(input logic [15:0] w[$], input bit toggle);
    for (int i = 0; i < w.size(); i++) begin
      int guard;
      bit took;
      guard = 0;
      took  = 1'b0;
      din       = w[i];
      din_valid = 1'b1;
      while (!took && guard < 100) begin
        took = din_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!took) fail("xfer_timeout");
      if (toggle) begin
        din_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) fail("done_timeout");
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {63'd0, din_ready}, 64'd0);
    check({tag, "_we"},    {63'd0, mem_we},    64'd0);
    check({tag, "_addr"},  {51'd0, mem_addr},  64'd0);
    check({tag, "_din"},   mem_din,            64'd0);
    check({tag, "_busy"},  {63'd0, busy},      64'd0);
    check({tag, "_done"},  {63'd0, done},      64'd0);
    check({tag, "_err"},   {63'd0, err},       64'd0);
  endtask

  initial begin
    int cyc;
    int n0;
    int d0;
    rst = 1'b1; start = 1'b0; start_idx = 13'd0; count = 14'd0;
    din = 16'd0; din_valid = 1'b0;
    w1  = '{16'h0010, 16'h0000, 16'h0000, 16'h0000};
    w2  = '{16'h1111, 16'h2222, 16'h3333, 16'h0444, 16'hAAAA, 16'hBBBB, 16'h0CCC, 16'h0011};
    w4a = '{16'hDEAD, 16'hBEEF};
    w4b = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h0004};
    w5a = '{16'h0101, 16'h0202};
    w5b = '{16'h0303, 16'h0004, 16'h0505, 16'h0606, 16'h0707, 16'h0008};
    w5all = '{16'h0101, 16'h0202, 16'h0303, 16'h0004, 16'h0505, 16'h0606, 16'h0707, 16'h0008};
    w6  = '{16'h0000, 16'h0000, 16'hFFF0, 16'h003F,
            16'h1234, 16'h0000, 16'h0000, 16'h0001,
            16'h0001, 16'h0000, 16'h0000, 16'h4000};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");
    mon_en = 1'b1;

    // Test 1: single entry at index 5.
    n0 = log_addr.size();
    expect_burst(5, w1, 1);
    do_start(5, 1);
    fork
      send_words(w1, 1'b0);
      wait_done(cyc);
    join
    check("t1_start_to_done", 64'(cyc), 64'd5);
    check("t1_nwrites", 64'(log_addr.size() - n0), 64'd1);
    check("t1_addr", {51'd0, log_addr[n0]}, 64'd5);
    check("t1_data", log_data[n0], 64'h0000_0000_0000_0010);
    @(posedge clk); #1;
    check("t1_done_one_cycle", {63'd0, done}, 64'd0);

    // Test 2: wrap from 8191 to 0, back-to-back words.
    n0 = log_addr.size();
    expect_burst(8191, w2, 2);
    chk_ready = 1'b1;
    do_start(8191, 2);
    fork
      send_words(w2, 1'b0);
      wait_done(cyc);
    join
    check("t2_start_to_done", 64'(cyc), 64'd10);
    check("t2_nwrites", 64'(log_addr.size() - n0), 64'd2);
    check("t2_addr0", {51'd0, log_addr[n0]}, 64'd8191);
    check("t2_addr1", {51'd0, log_addr[n0+1]}, 64'd0);
    check("t2_data0", log_data[n0], 64'h0444_3333_2222_1111);

    // Test 3: same burst with DIN_VALID toggling.
    d0 = n0;
    n0 = log_addr.size();
    expect_burst(8191, w2, 2);
    do_start(8191, 2);
    fork
      send_words(w2, 1'b1);
      wait_done(cyc);
    join
    chk_ready = 1'b0;
    check("t3_nwrites", 64'(log_addr.size() - n0), 64'd2);
    check("t3_data0_same", log_data[n0], log_data[d0]);
    check("t3_data1_same", log_data[n0+1], log_data[d0+1]);

    // Test 4: reset after two of four words, then a fresh single-entry burst.
    n0 = log_addr.size();
    do_start(100, 1);
    send_words(w4a, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midrst");
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_aborted_write", 64'(log_addr.size() - n0), 64'd0);
    expect_burst(200, w4b, 1);
    do_start(200, 1);
    fork
      send_words(w4b, 1'b0);
      wait_done(cyc);
    join
    check("t4_nwrites", 64'(log_addr.size() - n0), 64'd1);
    check("t4_addr", {51'd0, log_addr[n0]}, 64'd200);
    check("t4_data", log_data[n0], 64'h0004_00C3_00B2_00A1);

    // Test 5a: empty burst.
    @(posedge clk); #1;
    n0 = log_addr.size();
    do_start(20, 0);
    check("t5_zero_done", {63'd0, done}, 64'd1);
    check("t5_zero_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("t5_zero_done_pulse", {63'd0, done}, 64'd0);
    check("t5_zero_nowrite", 64'(log_addr.size() - n0), 64'd0);

    // Test 5b: START while busy is ignored.
    d0 = done_cnt;
    expect_burst(300, w5all, 2);
    do_start(300, 2);
    send_words(w5a, 1'b0);
    do_start(50, 1);
    fork
      send_words(w5b, 1'b0);
      wait_done(cyc);
    join
    repeat (8) @(posedge clk);
    #1;
    check("t5_nwrites", 64'(log_addr.size() - n0), 64'd2);
    check("t5_addr0", {51'd0, log_addr[n0]}, 64'd300);
    check("t5_addr1", {51'd0, log_addr[n0+1]}, 64'd301);
    check("t5_one_done", 64'(done_cnt - d0), 64'd1);
    check("t5_idle_after", {63'd0, busy}, 64'd0);

    // Test 6: negative z and reserved bits.
    n0 = log_addr.size();
    expect_burst(400, w6, 3);
    do_start(400, 3);
    fork
      send_words(w6, 1'b0);
      wait_done(cyc);
    join
    check("t6_err", {63'd0, err}, {63'd0, RangeChk});
    check("t6_nwrites", 64'(log_addr.size() - n0), RangeChk ? 64'd1 : 64'd3);
    check("t6_first_addr", {51'd0, log_addr[n0]}, RangeChk ? 64'd401 : 64'd400);
    @(posedge clk); #1;
    do_start(0, 0);
    check("t6_err_cleared", {63'd0, err}, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("model_queue_empty", 64'(exp_addr_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
